// File: rtl/seg7_scan_display.sv
// ----------------------------------------------------------------------------
// seg7_scan_display
//
// Time-multiplexed 7-segment display driver. A packed BCD/hex value is captured
// into a shadow register on a load strobe (unless the hold switch is on). The
// DIGITS digits are then scanned one at a time over a shared segment bus. Each
// digit slot lasts SCAN_DIV cycles and starts with GUARD cycles in which every
// digit enable is off, so that segment changes do not ghost onto neighbours.
//
// Parameters:
//   DIGITS    number of digits scanned (1..8)
//   SCAN_DIV  clock cycles per digit slot (>= GUARD+1)
//   GUARD     blank cycles at the start of each slot (>= 0)
//
// Ports:
//   clk       system clock
//   rst       asynchronous, active-high reset
//   value     packed digit nibbles, nibble k = value[4k+3:4k], k=0 is the LSD
//   load      capture value into the shadow register
//   hold      freeze the shadow register
//   hex_mode  1: nibbles 10..15 show A,b,C,d,E,F; 0: they show a dash
//   blank_lz  1: blank leading zero digits (digit 0 is never blanked)
//   seg       segments {g,f,e,d,c,b,a}, active-low, registered
//   an        digit enables, active-low, registered
//   led       hold indicator, registered copy of hold
// ----------------------------------------------------------------------------
module seg7_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  hold,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  led
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
    localparam logic [6:0]    SEG_OFF = 7'b1111111;
    localparam logic [6:0]    SEG_DASH = 7'b0111111;

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] shd;
    logic [3:0]          nib;
    logic [DIGITS-1:0]   zero_from;
    logic                blank;
    logic                gap;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   an_next;

    function automatic logic [6:0] decode(input logic [3:0] n, input logic hx);
        case (n)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return hx ? 7'b0001000 : SEG_DASH;
            4'hB:    return hx ? 7'b0000011 : SEG_DASH;
            4'hC:    return hx ? 7'b1000110 : SEG_DASH;
            4'hD:    return hx ? 7'b0100001 : SEG_DASH;
            4'hE:    return hx ? 7'b0000110 : SEG_DASH;
            default: return hx ? 7'b0001110 : SEG_DASH;
        endcase
    endfunction

    // Slot counter and digit index: idx advances whenever cnt wraps.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow register: hold overrides load, so a load coinciding with hold
    // going high is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shd <= '0;
        end else if (load && !hold) begin
            shd <= value;
        end
    end

    // zero_from[k] is set when every nibble from position k up to the MSD
    // is zero, i.e. digit k is a leading zero.
    always_comb begin
        logic acc;
        acc = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc          = acc & (shd[4*k +: 4] == 4'd0);
            zero_from[k] = acc;
        end
    end

    // The guard comparison is resolved at elaboration when GUARD is zero so
    // that no always-false compare against an unsigned counter is built.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign gap = 1'b0;
        end else begin : g_guard
            localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
            assign gap = (cnt < GUARD_C);
        end
    endgenerate

    // NOTE: every combinational output gets a default before any conditional
    // update, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        nib      = shd[4*idx +: 4];
        blank    = blank_lz && (idx != '0) && zero_from[idx];
        seg_next = blank ? SEG_OFF : decode(nib, hex_mode);
        an_next  = '1;
        if (!gap) begin
            an_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= '1;
            led <= 1'b0;
        end else begin
            seg <= seg_next;
            an  <= an_next;
            led <= hold;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_display
//
// Self-checking bench for seg7_scan_display with DIGITS=4, SCAN_DIV=4,
// GUARD=1. The reference model tracks only the number of clock edges since
// reset and the captured display value; slot position, digit index, blanking
// and enables are derived from those with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_seg7_scan_display;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int GUARD    = 1;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    localparam logic [6:0] CODES [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic                  clk = 1'b0;
    logic                  rst;
    logic [4*DIGITS-1:0]   value;
    logic                  load;
    logic                  hold;
    logic                  hex_mode;
    logic                  blank_lz;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  led;

    int                    vectors     = 0;
    int                    miscompares = 0;
    int                    cyc;         // edges since reset release
    logic [4*DIGITS-1:0]   m_shd;       // model of the captured value

    seg7_scan_display #(
        .DIGITS  (DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .GUARD   (GUARD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .load    (load),
        .hold    (hold),
        .hex_mode(hex_mode),
        .blank_lz(blank_lz),
        .seg     (seg),
        .an      (an),
        .led     (led)
    );

    always #5 clk = ~clk;

    // Expected segment pattern for the display state during cycle c.
    function automatic logic [6:0] ref_seg(input int c, input logic [15:0] s,
                                           input logic hx, input logic bl);
        int d;
        int upper;
        int n;
        d     = (c / SCAN_DIV) % DIGITS;
        upper = int'(s) >> (4 * d);
        n     = upper % 16;
        if (bl && d != 0 && upper == 0) return 7'b1111111;
        if (n > 9 && !hx) return 7'b0111111;
        return CODES[n];
    endfunction

    function automatic logic [3:0] ref_an(input int c);
        int d;
        d = (c / SCAN_DIV) % DIGITS;
        if ((c % SCAN_DIV) < GUARD) return 4'b1111;
        return ~(4'b0001 << d);
    endfunction

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, got, exp);
        end
    endtask

    // One clock edge: predict outputs from pre-edge state, clock, update the
    // model, then compare away from the edge.
    task automatic step();
        logic [6:0] es;
        logic [3:0] ea;
        logic       el;
        es = ref_seg(cyc, m_shd, hex_mode, blank_lz);
        ea = ref_an(cyc);
        el = hold;
        @(posedge clk);
        #1;
        if (load && !hold) m_shd = value;
        cyc++;
        check("seg", seg, es);
        check("an", {3'b000, an}, {3'b000, ea});
        check("led", {6'b0, led}, {6'b0, el});
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    // Assert reset now (asynchronously), check the outputs at once, release
    // on the next falling edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_seg", seg, 7'b1111111);
        check("rst_an", {3'b000, an}, 7'b0001111);
        check("rst_led", {6'b0, led}, 7'b0);
        @(negedge clk);
        rst   = 1'b0;
        cyc   = 0;
        m_shd = '0;
    endtask

    initial begin
        rst      = 1'b1;
        value    = '0;
        load     = 1'b0;
        hold     = 1'b0;
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        cyc      = 0;
        m_shd    = '0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Decimal digits, two full frames.
        do_load(16'h1234);
        run(2 * FRAME);

        // Hex nibble and its dash rendering.
        hex_mode = 1'b1;
        do_load(16'h00A5);
        run(FRAME);
        hex_mode = 1'b0;
        run(FRAME);

        // Leading-zero blanking, including the all-zero value.
        blank_lz = 1'b1;
        do_load(16'h0007);
        run(FRAME);
        do_load(16'h0000);
        run(FRAME);
        blank_lz = 1'b0;

        // Hold freezes the display; a load coinciding with hold rising is lost.
        do_load(16'h1111);
        run(3);
        value = 16'h2222;
        load  = 1'b1;
        hold  = 1'b1;
        step();
        load  = 1'b0;
        run(2);
        do_load(16'h9999);
        run(FRAME);
        hold = 1'b0;
        step();
        do_load(16'h9999);
        run(FRAME);

        // Reset in the middle of digit 2's slot, then restart from digit 0.
        while ((cyc % FRAME) != 2 * SCAN_DIV + 2) step();
        do_reset();
        run(FRAME + 2);

        // Randomized traffic with a bias towards values with leading zeros.
        for (int i = 0; i < 800; i++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 3))
                0:       mask = 16'h000F;
                1:       mask = 16'h00FF;
                2:       mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            value = 16'($urandom) & mask;
            load  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) hold = ~hold;
            if ($urandom_range(0, 9) == 0) hex_mode = ~hex_mode;
            if ($urandom_range(0, 9) == 0) blank_lz = ~blank_lz;
            step();
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
